// File: rtl/number_hit_resolver.sv
// number_hit_resolver
// Collects player/number-sprite collisions over one VGA frame and resolves
// them at the frame boundary into a single registered hit pulse. A hit
// carries the earliest-touched number index and the full collision mask.
// A frame-counted cooldown then suppresses further hits while the player
// is still overlapping a sprite.
module number_hit_resolver #(
    parameter int NUM_COUNT       = 12,
    parameter int IDX_W           = 4,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 playerDR,
    input  logic [NUM_COUNT-1:0] numbersDR,
    output logic                 singleHit,
    output logic [IDX_W-1:0]     hitIndex,
    output logic [NUM_COUNT-1:0] hitMask,
    output logic [CNT_W-1:0]     hitCount,
    output logic                 coolingDown
);

    // A zero-length cooldown still needs a one-bit counter so the
    // register exists and stays at zero.
    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    typedef enum logic [0:0] {
        ST_ARMED    = 1'b0,
        ST_COOLDOWN = 1'b1
    } state_t;

    // Index of the lowest set bit; zero when the vector is empty.
    // Scanning downwards lets the lowest index win.
    function automatic logic [IDX_W-1:0] f_low_idx(input logic [NUM_COUNT-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_COUNT - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    state_t                 r_state;
    logic [CD_W-1:0]        r_cdCnt;
    logic [NUM_COUNT-1:0]   r_colMask;
    logic [IDX_W-1:0]       r_capIdx;
    logic                   r_capFlag;

    logic [NUM_COUNT-1:0]   w_term;
    logic                   w_termHit;
    logic [IDX_W-1:0]       w_lowIdx;
    logic                   w_frameHit;

    // The player's drawing request gates every number request on this pixel.
    assign w_term     = numbersDR & {NUM_COUNT{playerDR}};
    assign w_termHit  = (w_term != '0);
    assign w_lowIdx   = f_low_idx(w_term);
    assign w_frameHit = (r_colMask != '0);

    // Per-frame collision accumulation; SOF restarts the mask with the
    // current pixel, which therefore belongs to the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_colMask <= '0;
            r_capIdx  <= '0;
            r_capFlag <= 1'b0;
        end else if (startOfFrame) begin
            r_colMask <= w_term;
            r_capFlag <= w_termHit;
            if (w_termHit) begin
                r_capIdx <= w_lowIdx;
            end else begin
                r_capIdx <= '0;
            end
        end else begin
            r_colMask <= r_colMask | w_term;
            // Only the first colliding pixel of a frame sets the index,
            // so raster order decides priority across pixels.
            if (!r_capFlag && w_termHit) begin
                r_capIdx  <= w_lowIdx;
                r_capFlag <= 1'b1;
            end else begin
                r_capIdx  <= r_capIdx;
                r_capFlag <= r_capFlag;
            end
        end
    end

    // Frame-boundary resolution FSM with registered hit outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_ARMED;
            r_cdCnt     <= '0;
            singleHit   <= 1'b0;
            hitIndex    <= '0;
            hitMask     <= '0;
            hitCount    <= '0;
            coolingDown <= 1'b0;
        end else begin
            // Pulse is one cycle wide unless re-asserted below.
            singleHit <= 1'b0;
            if (startOfFrame) begin
                case (r_state)
                    ST_ARMED: begin
                        if (w_frameHit) begin
                            singleHit <= 1'b1;
                            hitIndex  <= r_capIdx;
                            hitMask   <= r_colMask;
                            if (hitCount != '1) begin
                                hitCount <= hitCount + CNT_W'(1);
                            end else begin
                                hitCount <= hitCount;
                            end
                            if (COOLDOWN_FRAMES > 0) begin
                                r_state     <= ST_COOLDOWN;
                                r_cdCnt     <= CD_W'(COOLDOWN_FRAMES);
                                coolingDown <= 1'b1;
                            end else begin
                                r_state     <= ST_ARMED;
                                r_cdCnt     <= '0;
                                coolingDown <= 1'b0;
                            end
                        end else begin
                            r_state <= ST_ARMED;
                        end
                    end
                    ST_COOLDOWN: begin
                        // Collisions of the ended frame are discarded here.
                        if (r_cdCnt == CD_W'(1)) begin
                            r_state     <= ST_ARMED;
                            r_cdCnt     <= '0;
                            coolingDown <= 1'b0;
                        end else begin
                            r_state     <= ST_COOLDOWN;
                            r_cdCnt     <= r_cdCnt - CD_W'(1);
                            coolingDown <= 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= ST_ARMED;
                        r_cdCnt     <= '0;
                        coolingDown <= 1'b0;
                    end
                endcase
            end else begin
                r_state <= r_state;
                r_cdCnt <= r_cdCnt;
            end
        end
    end

endmodule

// File: tb/tb_number_hit_resolver.sv
// Directed bench for number_hit_resolver. Two instances share stimulus:
// dut_a uses a 3-frame cooldown, dut_b has no cooldown and a 2-bit counter.
module tb_number_hit_resolver;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        playerDR;
    logic [11:0] numbersDR;

    logic        a_hit, a_cd;
    logic [3:0]  a_idx;
    logic [11:0] a_mask;
    logic [7:0]  a_cnt;

    logic        b_hit, b_cd;
    logic [3:0]  b_idx;
    logic [11:0] b_mask;
    logic [1:0]  b_cnt;

    int n_total;
    int n_bad;

    number_hit_resolver #(
        .NUM_COUNT(12), .IDX_W(4), .COOLDOWN_FRAMES(3), .CNT_W(8)
    ) dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .playerDR(playerDR), .numbersDR(numbersDR),
        .singleHit(a_hit), .hitIndex(a_idx), .hitMask(a_mask),
        .hitCount(a_cnt), .coolingDown(a_cd)
    );

    number_hit_resolver #(
        .NUM_COUNT(12), .IDX_W(4), .COOLDOWN_FRAMES(0), .CNT_W(2)
    ) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .playerDR(playerDR), .numbersDR(numbersDR),
        .singleHit(b_hit), .hitIndex(b_idx), .hitMask(b_mask),
        .hitCount(b_cnt), .coolingDown(b_cd)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one pixel for one clock; returns 1 time unit after the edge.
    task automatic pix(input logic sof, input logic pdr, input logic [11:0] nd);
        startOfFrame = sof;
        playerDR     = pdr;
        numbersDR    = nd;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        playerDR     = 1'b0;
        numbersDR    = 12'h000;
    endtask

    // Three empty frames; each SOF is checked for no pulse on dut_a.
    task automatic idle_frames(input string tag);
        for (int f = 0; f < 3; f++) begin
            pix(1'b0, 1'b0, 12'h000);
            pix(1'b0, 1'b0, 12'h000);
            pix(1'b1, 1'b0, 12'h000);
            chk(tag, 32'(a_hit), 32'd0);
        end
        chk({tag, "_cd_end"}, 32'(a_cd), 32'd0);
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        playerDR     = 1'b0;
        numbersDR    = 12'h000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit",  32'(a_hit),  32'd0);
        chk("rst_idx",  32'(a_idx),  32'd0);
        chk("rst_mask", 32'(a_mask), 32'd0);
        chk("rst_cnt",  32'(a_cnt),  32'd0);
        chk("rst_cd",   32'(a_cd),   32'd0);
        resetN = 1'b1;

        // Frame 0 start.
        pix(1'b1, 1'b0, 12'h000);
        chk("f0_sof_nohit", 32'(a_hit), 32'd0);

        // Single hit on number 4 for three pixels.
        pix(1'b0, 1'b1, 12'h010);
        pix(1'b0, 1'b1, 12'h010);
        pix(1'b0, 1'b1, 12'h010);
        pix(1'b0, 1'b0, 12'h000);
        pix(1'b1, 1'b0, 12'h000);
        chk("single_hit",  32'(a_hit),  32'd1);
        chk("single_idx",  32'(a_idx),  32'd4);
        chk("single_mask", 32'(a_mask), 32'h010);
        chk("single_cnt",  32'(a_cnt),  32'd1);
        chk("single_cd",   32'(a_cd),   32'd1);
        chk("sat_cnt0",    32'(b_cnt),  32'd1);
        pix(1'b0, 1'b0, 12'h000);
        chk("pulse_width", 32'(a_hit),  32'd0);

        // Cooldown: collision on number 5 in frames 1..4.
        for (int f = 1; f <= 4; f++) begin
            pix(1'b0, 1'b1, 12'h020);
            pix(1'b0, 1'b0, 12'h000);
            pix(1'b1, 1'b0, 12'h000);
            chk($sformatf("cd_hit_f%0d", f), 32'(a_hit), (f == 4) ? 32'd1 : 32'd0);
            chk($sformatf("cd_flag_f%0d", f), 32'(a_cd), (f == 3) ? 32'd0 : 32'd1);
            chk($sformatf("sat_hit_f%0d", f), 32'(b_hit), 32'd1);
            chk($sformatf("sat_cnt_f%0d", f), 32'(b_cnt), (f == 1) ? 32'd2 : 32'd3);
        end
        chk("cd_idx", 32'(a_idx), 32'd5);
        chk("cd_cnt", 32'(a_cnt), 32'd2);
        idle_frames("rearm1");

        // Priority across pixels: 11 first, then 0/1; masked 6 ignored.
        pix(1'b0, 1'b1, 12'h800);
        pix(1'b0, 1'b0, 12'h040);
        pix(1'b0, 1'b1, 12'h003);
        pix(1'b1, 1'b0, 12'h000);
        chk("prio_hit",  32'(a_hit),  32'd1);
        chk("prio_idx",  32'(a_idx),  32'd11);
        chk("prio_mask", 32'(a_mask), 32'h803);
        chk("prio_cnt",  32'(a_cnt),  32'd3);
        idle_frames("rearm2");

        // Priority within one pixel: lowest index wins.
        pix(1'b0, 1'b1, 12'h804);
        pix(1'b1, 1'b0, 12'h000);
        chk("tie_hit",  32'(a_hit),  32'd1);
        chk("tie_idx",  32'(a_idx),  32'd2);
        chk("tie_mask", 32'(a_mask), 32'h804);
        idle_frames("rearm3");

        // Collision only on the SOF cycle belongs to the new frame.
        pix(1'b0, 1'b0, 12'h000);
        pix(1'b0, 1'b0, 12'h000);
        pix(1'b1, 1'b1, 12'h100);
        chk("bnd_sof_nohit", 32'(a_hit), 32'd0);
        chk("bnd_hold_idx",  32'(a_idx), 32'd2);
        pix(1'b0, 1'b0, 12'h000);
        pix(1'b0, 1'b0, 12'h000);
        pix(1'b1, 1'b0, 12'h000);
        chk("bnd_hit",  32'(a_hit),  32'd1);
        chk("bnd_idx",  32'(a_idx),  32'd8);
        chk("bnd_mask", 32'(a_mask), 32'h100);
        chk("bnd_cnt",  32'(a_cnt),  32'd5);

        // Asynchronous reset mid-frame and mid-cooldown.
        startOfFrame = 1'b0;
        playerDR     = 1'b1;
        numbersDR    = 12'h001;
        #2;
        resetN = 1'b0;
        #1;
        chk("arst_hit",  32'(a_hit),  32'd0);
        chk("arst_idx",  32'(a_idx),  32'd0);
        chk("arst_mask", 32'(a_mask), 32'h000);
        chk("arst_cnt",  32'(a_cnt),  32'd0);
        chk("arst_cd",   32'(a_cd),   32'd0);
        chk("arst_bcnt", 32'(b_cnt),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        pix(1'b0, 1'b1, 12'h001);
        pix(1'b1, 1'b0, 12'h000);
        chk("post_rst_hit", 32'(a_hit), 32'd1);
        chk("post_rst_idx", 32'(a_idx), 32'd0);
        chk("post_rst_cnt", 32'(a_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
